// File: rtl/search_datapath.sv
// Linear key search over a small write-anywhere memory.
// Controller sequences load/mv_addr; found reports hit or exhaustion.
module search_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] key,
    input  logic              key_latch,
    input  logic              load,
    input  logic              mv_addr,
    output logic              found,
    output logic              hit,
    output logic              exhausted,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] match_addr,
    output logic [DATA_W-1:0] data_q
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] rd_word;
    logic              match_now;

    assign rd_word   = mem[addr];
    assign match_now = (rd_word == key_q);
    assign found     = hit | exhausted;

    // Memory survives reset; writes are simply blocked while it is held.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q      <= '0;
            addr       <= '0;
            data_q     <= '0;
            match_addr <= '0;
            hit        <= 1'b0;
            exhausted  <= 1'b0;
        end else if (key_latch) begin
            key_q      <= key;
            addr       <= '0;
            data_q     <= '0;
            match_addr <= '0;
            hit        <= 1'b0;
            exhausted  <= 1'b0;
        end else if (!found) begin
            if (load) begin
                data_q <= rd_word;
                if (match_now) begin
                    hit        <= 1'b1;
                    match_addr <= addr;
                end
            end
            // A hit in the same cycle as the final advance must win.
            if (mv_addr) begin
                if (addr != LAST) begin
                    addr <= addr + 1'b1;
                end else if (!(load && match_now)) begin
                    exhausted <= 1'b1;
                end
            end
        end
    end

endmodule
